// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel sink: 160x120 frame geometry,
// colour encoding and the {addr, colour} entry format held in the plot FIFO.
package vga_pkg;

  localparam int H_RES    = 160;
  localparam int V_RES    = 120;
  localparam int FB_WORDS = H_RES * V_RES;
  localparam int ADDR_W   = 15;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_CLEAR
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } pix_entry_t;

  // y*160 + x using shifts only: y*128 + y*32 + x.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 7) + (yw << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/vga_pixel_sink_if.sv
// Pixel-plot, clear-screen and framebuffer write signals of the VGA pixel sink.
// master = game datapath / RAM side, slave = the sink itself.
interface vga_pixel_sink_if;
  import vga_pkg::*;

  logic                plot;
  logic [7:0]          x;
  logic [6:0]          y;
  logic [COLOUR_W-1:0] colour;
  logic                ready;
  logic                clear_req;
  logic [COLOUR_W-1:0] clear_colour;
  logic                clear_busy;
  logic [ADDR_W-1:0]   mem_addr;
  logic [COLOUR_W-1:0] mem_data;
  logic                mem_we;
  logic                mem_ready;

  modport master (
    output plot, x, y, colour, clear_req, clear_colour, mem_ready,
    input  ready, clear_busy, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  plot, x, y, colour, clear_req, clear_colour, mem_ready,
    output ready, clear_busy, mem_addr, mem_data, mem_we
  );

endinterface

// File: rtl/pixel_fifo.sv
// Show-ahead FIFO for buffered plot entries; registered count with full/empty
// flags. DEPTH must be a power of two, at least 2.
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(pix_entry_t),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/vga_pixel_sink.sv
// Receives plot commands, queues them as framebuffer writes and runs a hardware
// clear-screen sequence. Optional drop counter: VGA_PIXEL_SINK_CLIP_COUNT_EN.
module vga_pixel_sink #(
  parameter int DEPTH = 4,
  parameter int H_RES = vga_pkg::H_RES,
  parameter int V_RES = vga_pkg::V_RES
) (
  input  logic            clk_i,
  input  logic            reset_i,
  vga_pixel_sink_if.slave pix_if
`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
  ,
  output logic [7:0]      drop_count_o
`endif
);
  import vga_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  state_e              state_q;
  logic                busy_q;
  logic [COLOUR_W-1:0] clr_colour_q;
  logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [COLOUR_W-1:0] mem_data_q;

  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  pix_entry_t          wr_entry, rd_entry;

  logic in_range, accept, push, pop, slot_free, pix_out, ready, clear_take;

  assign in_range = (int'(pix_if.x) < H_RES) && (int'(pix_if.y) < V_RES);
  assign accept   = pix_if.plot && ready;
  assign push     = accept && in_range && !fifo_full;
  assign wr_entry = '{addr: fb_addr(pix_if.x, pix_if.y), colour: pix_if.colour};

  // A pixel sitting on the write port still counts as a held entry.
  assign pix_out   = mem_we_q && (state_q != S_CLEAR);
  assign ready     = (int'(fifo_count) + int'(pix_out)) < DEPTH;
  assign slot_free = !mem_we_q || pix_if.mem_ready;

  assign clear_take  = pix_if.clear_req && (state_q == S_IDLE);
  assign drain_cnt_d = CNT_W'(int'(fifo_count) + int'(push) - int'(pop));

  always_comb begin
    pop = 1'b0;
    case (state_q)
      S_IDLE:  pop = slot_free && !fifo_empty;
      S_DRAIN: pop = slot_free && (drain_cnt_q != '0);
      default: pop = 1'b0;
    endcase
  end

  pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(pix_entry_t))
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (reset_i),
    .wr_en_i   (push),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (rd_entry),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      clr_colour_q <= BLACK;
      drain_cnt_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= BLACK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= rd_entry.addr;
            mem_data_q <= rd_entry.colour;
          end else if (pix_if.mem_ready) begin
            mem_we_q <= 1'b0;
          end
          // drain_cnt_d includes a plot accepted in the same cycle as the clear.
          if (clear_take) begin
            busy_q       <= 1'b1;
            clr_colour_q <= pix_if.clear_colour;
            drain_cnt_q  <= drain_cnt_d;
            state_q      <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= rd_entry.addr;
            mem_data_q  <= rd_entry.colour;
            drain_cnt_q <= drain_cnt_q - 1'b1;
          end else if (pix_if.mem_ready) begin
            mem_we_q <= 1'b0;
          end
          if ((drain_cnt_q == '0) && slot_free) begin
            state_q    <= S_CLEAR;
            mem_we_q   <= 1'b1;
            mem_addr_q <= '0;
            mem_data_q <= clr_colour_q;
          end
        end
        S_CLEAR: begin
          // mem_addr_q doubles as the clear counter; it moves only on accepted writes.
          if (pix_if.mem_ready) begin
            if (mem_addr_q == LAST_ADDR) begin
              mem_we_q <= 1'b0;
              busy_q   <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              mem_addr_q <= mem_addr_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pix_if.ready      = ready;
  assign pix_if.clear_busy = busy_q;
  assign pix_if.mem_we     = mem_we_q;
  assign pix_if.mem_addr   = mem_addr_q;
  assign pix_if.mem_data   = mem_data_q;

`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt_q <= '0;
    end else if (accept && !in_range && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign drop_count_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Bench for vga_pixel_sink: vector table, clear/backpressure/reset sequences
// and random plots against a queue-based model of expected framebuffer writes.
module tb_vga_pixel_sink;
  import vga_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  typedef struct {
    int addr;
    int data;
    bit last;
    bit pixel;
  } wr_t;

  typedef struct {
    int x;
    int y;
    int colour;
    bit exp_we;
    int exp_addr;
  } vec_t;

  wr_t  exp_q[$];
  int   pend_plots;
  int   m_drops;
  bit   m_busy;
  bit   prev_stall;
  int   prev_addr;
  int   prev_data;
  vec_t vecs[9];

  vga_pixel_sink_if bus();
`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
  logic [7:0] drop_count;
`endif

  vga_pixel_sink #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .pix_if  (bus)
`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
    ,
    .drop_count_o (drop_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      if (errors <= 60) $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend_plots = 0;
    m_drops    = 0;
    m_busy     = 1'b0;
    prev_stall = 1'b0;
    prev_addr  = 0;
    prev_data  = 0;
  endtask

  // Called just after a negedge with inputs set; consumes one clock edge.
  task automatic step();
    bit  s_we, s_rdy, s_plot, s_clr, mb, acc;
    int  s_addr, s_data, px, py, pc, cc;
    wr_t w;
    #1;
    check("ready", int'(bus.ready), int'(pend_plots < DEPTH));
    check("clear_busy", int'(bus.clear_busy), int'(m_busy));
    if (prev_stall) begin
      check("hold_we", int'(bus.mem_we), 1);
      check("hold_addr", int'(bus.mem_addr), prev_addr);
      check("hold_data", int'(bus.mem_data), prev_data);
    end
    s_we   = bus.mem_we;
    s_rdy  = bus.mem_ready;
    s_addr = int'(bus.mem_addr);
    s_data = int'(bus.mem_data);
    s_plot = bus.plot;
    s_clr  = bus.clear_req;
    px     = int'(bus.x);
    py     = int'(bus.y);
    pc     = int'(bus.colour);
    cc     = int'(bus.clear_colour);
    mb     = m_busy;
    acc    = s_plot && (pend_plots < DEPTH);
    prev_stall = s_we && !s_rdy;
    prev_addr  = s_addr;
    prev_data  = s_data;
    @(posedge clk);
    if (s_we && s_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", s_addr, -1);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", s_addr, w.addr);
        check("wr_data", s_data, w.data);
        if (w.pixel) pend_plots--;
        if (w.last) m_busy = 1'b0;
      end
    end
    if (acc) begin
      if (px < H_RES && py < V_RES) begin
        exp_q.push_back('{py * H_RES + px, pc, 1'b0, 1'b1});
        pend_plots++;
      end else if (m_drops < 255) begin
        m_drops++;
      end
    end
    if (s_clr && !mb) begin
      m_busy = 1'b1;
      for (int a = 0; a < FB_WORDS; a++) exp_q.push_back('{a, cc, (a == FB_WORDS - 1), 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic set_plot(input int px, input int py, input int pc);
    bus.plot   = 1'b1;
    bus.x      = 8'(px);
    bus.y      = 7'(py);
    bus.colour = 3'(pc);
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int  n;
    int  stall_n;
    bit  acc;
    checks = 0;
    errors = 0;
    model_reset();
    reset            = 1'b1;
    bus.plot         = 1'b0;
    bus.x            = '0;
    bus.y            = '0;
    bus.colour       = '0;
    bus.clear_req    = 1'b0;
    bus.clear_colour = '0;
    bus.mem_ready    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(bus.ready), 1);
    check("rst_busy", int'(bus.clear_busy), 0);
    check("rst_we", int'(bus.mem_we), 0);
    check("rst_addr", int'(bus.mem_addr), 0);
    check("rst_data", int'(bus.mem_data), 0);
`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
    check("rst_drop_count", int'(drop_count), 0);
`endif
    reset = 1'b0;

    // x, y, colour, write expected, address
    vecs[0] = '{10, 2, 5, 1'b1, 330};
    vecs[1] = '{159, 119, 7, 1'b1, 19199};
    vecs[2] = '{160, 0, 1, 1'b0, 0};
    vecs[3] = '{0, 120, 2, 1'b0, 0};
    vecs[4] = '{0, 0, 6, 1'b1, 0};
    vecs[5] = '{159, 0, 3, 1'b1, 159};
    vecs[6] = '{0, 119, 4, 1'b1, 19040};
    vecs[7] = '{255, 127, 7, 1'b0, 0};
    vecs[8] = '{100, 60, 1, 1'b1, 9700};
    for (int i = 0; i < 9; i++) begin
      set_plot(vecs[i].x, vecs[i].y, vecs[i].colour);
      step();
      bus.plot = 1'b0;
      check("tbl_we_accept_cycle", int'(bus.mem_we), 0);
      step();
      check("tbl_we", int'(bus.mem_we), int'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        check("tbl_addr", int'(bus.mem_addr), vecs[i].exp_addr);
        check("tbl_data", int'(bus.mem_data), vecs[i].colour);
      end
      step();
      check("tbl_we_single", int'(bus.mem_we), 0);
    end
`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
    check("tbl_drop_count", int'(drop_count), 3);
`endif

    // Backpressure: four plots fill the sink, the fifth waits for a write.
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_plot(i * 20 + 3, i * 3 + 1, i + 1);
      check("bp_ready_before", int'(bus.ready), 1);
      step();
    end
    set_plot(77, 44, 7);
    check("bp_ready_full", int'(bus.ready), 0);
    repeat (3) step();
    bus.mem_ready = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      acc = bus.ready;
      step();
      n++;
    end
    check("bp_fifth_accepted", int'(acc), 1);
    bus.plot = 1'b0;
    drain("bp_drain", 100);

    // Clear with two plots queued ahead of it; stall on the last clear address.
    bus.mem_ready = 1'b0;
    set_plot(30, 40, 3);
    step();
    set_plot(7, 8, 6);
    step();
    bus.plot         = 1'b0;
    bus.clear_req    = 1'b1;
    bus.clear_colour = 3'b000;
    check("clr1_busy_before", int'(bus.clear_busy), 0);
    step();
    bus.clear_req = 1'b0;
    check("clr1_busy_after", int'(bus.clear_busy), 1);
    n       = 0;
    stall_n = 0;
    while (bus.clear_busy && n < 25000) begin
      if (bus.mem_we && bus.mem_addr == 15'd19199 && bus.mem_data == 3'b000 && stall_n < 3) begin
        bus.mem_ready = 1'b0;
        stall_n++;
      end else begin
        bus.mem_ready = 1'b1;
      end
      step();
      n++;
    end
    check("clr1_done", int'(bus.clear_busy), 0);
    check("clr1_all_written", exp_q.size(), 0);
    check("clr1_last_stalled", stall_n, 3);

    // Plot and a second clear_req while a clear is running.
    bus.mem_ready    = 1'b1;
    bus.clear_req    = 1'b1;
    bus.clear_colour = 3'b110;
    step();
    bus.clear_req = 1'b0;
    n = 0;
    while (!(bus.mem_we && bus.mem_addr >= 15'd5000) && n < 10000) begin
      bus.mem_ready = ($urandom_range(0, 7) != 0);
      step();
      n++;
    end
    check("clr2_mid_busy", int'(bus.clear_busy), 1);
    set_plot(5, 5, 2);
    step();
    bus.plot         = 1'b0;
    bus.clear_req    = 1'b1;
    bus.clear_colour = 3'b001;
    step();
    bus.clear_req = 1'b0;
    n = 0;
    while (bus.clear_busy && n < 30000) begin
      bus.mem_ready = ($urandom_range(0, 7) != 0);
      step();
      n++;
    end
    check("clr2_done", int'(bus.clear_busy), 0);
    bus.mem_ready = 1'b1;
    n = 0;
    while (!bus.mem_we && n < 10) begin
      step();
      n++;
    end
    check("clr2_plot_addr", int'(bus.mem_addr), 805);
    check("clr2_plot_data", int'(bus.mem_data), 2);
    drain("clr2_drain", 20);

    // Random plots with random RAM stalls.
    for (int c = 0; c < 600; c++) begin
      bus.plot      = ($urandom_range(0, 1) != 0);
      bus.x         = 8'($urandom_range(0, 170));
      bus.y         = 7'($urandom_range(0, 127));
      bus.colour    = 3'($urandom);
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.plot      = 1'b0;
    bus.mem_ready = 1'b1;
    drain("rand_drain", 200);
`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
    check("rand_drop_count", int'(drop_count), m_drops);
    for (int c = 0; c < 260; c++) begin
      set_plot(200, 3, 1);
      step();
    end
    bus.plot = 1'b0;
    check("drop_count_saturated", int'(drop_count), 255);
`endif

    // Reset in the middle of a clear with a plot queued behind it.
    bus.clear_req    = 1'b1;
    bus.clear_colour = 3'b101;
    step();
    bus.clear_req = 1'b0;
    set_plot(1, 1, 4);
    step();
    bus.plot = 1'b0;
    n = 0;
    while (!(bus.mem_we && bus.mem_addr == 15'd1000) && n < 3000) begin
      step();
      n++;
    end
    check("rstmid_reached_1000", int'(bus.mem_addr), 1000);
    reset = 1'b1;
    #1;
    check("rstmid_busy", int'(bus.clear_busy), 0);
    check("rstmid_we", int'(bus.mem_we), 0);
    check("rstmid_ready", int'(bus.ready), 1);
    check("rstmid_addr", int'(bus.mem_addr), 0);
`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
    check("rstmid_drop_count", int'(drop_count), 0);
`endif
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) step();
    check("rstmid_no_write", int'(bus.mem_we), 0);
    check("rstmid_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_sink.md
Name: vga_pixel_sink

Overview:
- Receiving end of the pixel-plot interface that game datapaths drive (x, y, colour, plot).
- Buffers plot commands in a small FIFO and converts 160x120 coordinates to linear framebuffer addresses.
- Writes the buffered pixels into a framebuffer RAM port, stalling whenever the RAM arbiter withholds `mem_ready`.
- Also provides a hardware clear-screen sequence, so game logic no longer needs its own full-screen draw loop.

Parameters:
- DEPTH, 4, plot FIFO entries; power of two, minimum 2.
- H_RES, 160, horizontal pixels.
- V_RES, 120, vertical pixels.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- plot  in  1  pixel-write request; accepted on a clk edge when plot=1 and ready=1.
- x  in  8  pixel column.
- y  in  7  pixel row.
- colour  in  3  RGB pixel value.
- ready  out  1  FIFO not full; a plot is accepted this cycle.
- clear_req  in  1  one-cycle pulse; requests fill of the whole screen with clear_colour.
- clear_colour  in  3  fill value; sampled on the cycle clear_req is accepted.
- clear_busy  out  1  high from clear acceptance until the last clear write completes.
- mem_addr  out  15  framebuffer address = y*H_RES + x.
- mem_data  out  3  framebuffer write data.
- mem_we  out  1  write strobe; the write completes on a cycle where mem_we=1 and mem_ready=1.
- mem_ready  in  1  RAM port available this cycle.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset values:
  - ready=1, clear_busy=0, mem_we=0, mem_addr=0, mem_data=0.
  - FIFO empty, FSM in IDLE.
- Reset mid-operation aborts everything: FIFO contents and any in-progress clear are discarded, with no partial-write guarantees.
- Accept and range check:
  - A plot with x>=H_RES or y>=V_RES is accepted (consumes the handshake) but dropped; it is never enqueued.
  - In-range plots are enqueued as {addr, colour}.
  - The address is computed at enqueue: (y<<7)+(y<<5)+x, 15-bit, maximum 19199.
- FIFO:
  - ready=0 when DEPTH entries are held.
  - Enqueue and dequeue in the same cycle while full is allowed only after the dequeue; ready is computed from the registered count, not combinationally from mem_ready.
- Write port: mem_addr, mem_data and mem_we are registered. Latency from plot accept to mem_we=1 is 1 cycle when the FIFO is empty and the FSM is IDLE.
- Write hold: mem_we, mem_addr and mem_data hold stable until mem_ready=1. The next entry is presented on the following cycle, giving back-to-back throughput of 1 write per cycle.
- FSM states:
  - IDLE: drain the FIFO to memory. clear_req=1 latches clear_colour, sets clear_busy=1 and moves to DRAIN.
  - DRAIN: keep writing FIFO entries; move to CLEAR when the FIFO is empty and no write is pending.
  - CLEAR: write addresses 0..H_RES*V_RES-1 with the latched clear colour; the 15-bit counter advances only on mem_ready=1.
  - CLEAR exit: after address 19199 is written, clear_busy drops the next cycle and the FSM returns to IDLE.
- Ordering rules:
  - Plots accepted before or in the same cycle as clear_req are written before the clear.
  - Plots accepted during DRAIN or CLEAR stay queued (ready falls when full) and are written after the clear.
  - clear_req while clear_busy=1 is ignored.
- Boundaries:
  - x=159, y=119 maps to 19199.
  - x=160 is dropped.
  - x=0, y=0 maps to 0.
  - A mem_ready stall on the last clear address extends clear_busy by the same number of cycles.

Optional Feature:
- Macro: VGA_PIXEL_SINK_CLIP_COUNT_EN.
- Defined: adds output drop_count (8 bits, reset 0). It increments once per accepted out-of-range plot, saturates at 255, and is cleared only by reset.
- Undefined: the port and counter are absent; out-of-range plots are still silently dropped.

Decomposition:
- Shared package vga_pkg holds:
  - constants H_RES=160, V_RES=120, FB_WORDS=19200, ADDR_W=15, COLOUR_W=3;
  - the colour constants BLACK=3'b000 and WHITE=3'b111.
- The FIFO is the natural sub-module: `pixel_fifo` (parameterised DEPTH and width 18, registered count, full/empty flags).
- Address conversion and the FSM stay in vga_pixel_sink.

Test Plan:
- Single plot: x=10, y=2, colour=3'b101, mem_ready=1 → one cycle later mem_we=1, mem_addr=330, mem_data=5, for exactly one cycle.
- Backpressure: mem_ready=0 while 5 plots are presented with DEPTH=4 → ready=0 after the 4th accept. Releasing mem_ready then gives 4 in-order writes, and the 5th plot is accepted when ready rises.
- Corner coordinates:
  - (159,119) → address 19199.
  - (160,0) and (0,120) → no write.
  - With VGA_PIXEL_SINK_CLIP_COUNT_EN defined, drop_count=2.
- Clear during queue: 2 queued plots, then clear_req with clear_colour=0 → both plots written first, then 19200 writes of 0 to addresses 0..19199. clear_busy goes high on the cycle after clear_req and low one cycle after the write to 19199.
- Plot during clear: plot (5,5) in mid-CLEAR → mem_addr=805 is written after address 19199; a second clear_req during busy produces no extra writes.
- Async reset mid-clear: assert reset at clear address 1000 → clear_busy=0, mem_we=0 and ready=1 immediately, with no further writes after reset is released.
